gerenciador_de_posicionamento: RTL and testbench

Fleet-placement controller: the player places a fixed fleet on the 5-column × 7-row board one ship at a time using coordinates, orientation and a confirm button. It writes the final ship map `mapa0..mapa4` that `gerenciador_de_ataque` consumes. Each placement is bounds-checked and overlap-checked. `pronto` hands control to the attack phase once every ship is placed.

---
 rtl/batalha_naval_pkg.sv | 30 +++
 rtl/mascara_navio.sv | 51 +++++
 rtl/gerenciador_de_posicionamento.sv | 148 ++++++++++++++
 tb/tb_gerenciador_de_posicionamento.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/batalha_naval_pkg.sv
// Shared board and fleet definitions for the naval-battle blocks.
// Placement and attack controllers import the board geometry from here.
package batalha_naval_pkg;

  localparam int N_COLUNAS  = 5;
  localparam int N_LINHAS   = 7;
  localparam int NUM_NAVIOS = 3;
  localparam int N_CELULAS  = N_COLUNAS * N_LINHAS;

  localparam logic [3:0] TAMANHO_NAVIO [0:NUM_NAVIOS-1] = '{4'd3, 4'd2, 4'd1};

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    POSICIONANDO = 2'd1,
    CONCLUIDO    = 2'd2
  } estado_t;

  // Size lookup; an unknown index degrades to the smallest ship.
  function automatic logic [3:0] tamanho_do_navio(input logic [1:0] indice);
    logic [3:0] tamanho;
    case (indice)
      2'd0:    tamanho = TAMANHO_NAVIO[0];
      2'd1:    tamanho = TAMANHO_NAVIO[1];
      2'd2:    tamanho = TAMANHO_NAVIO[2];
      default: tamanho = 4'd1;
    endcase
    return tamanho;
  endfunction

endpackage

// File: rtl/mascara_navio.sv
// Combinational ship footprint: column-major cell mask (bit 7*C+L) of a
// candidate ship plus an in-bounds flag. The mask is zero when out of bounds.
module mascara_navio
  import batalha_naval_pkg::*;
(
  input  logic [2:0]           coluna,
  input  logic [2:0]           linha,
  input  logic                 orientacao,
  input  logic [3:0]           tamanho,
  output logic [N_CELULAS-1:0] mascara,
  output logic                 dentro
);

  logic [3:0] col_ini_s;
  logic [3:0] lin_ini_s;
  logic [3:0] col_fim_s;
  logic [3:0] lin_fim_s;

  // Ship bounding rectangle, widened to 4 bits so c+n-1 cannot wrap.
  always_comb begin
    col_ini_s = {1'b0, coluna};
    lin_ini_s = {1'b0, linha};
    if (orientacao) begin
      col_fim_s = col_ini_s;
      lin_fim_s = lin_ini_s + tamanho - 4'd1;
    end else begin
      col_fim_s = col_ini_s + tamanho - 4'd1;
      lin_fim_s = lin_ini_s;
    end
  end

  // End point inside the board implies the origin is too (end >= origin).
  always_comb begin
    dentro = (tamanho != 4'd0) &&
             (col_fim_s <= 4'(N_COLUNAS - 1)) &&
             (lin_fim_s <= 4'(N_LINHAS - 1));
  end

  // Cell is covered when it lies within the rectangle.
  always_comb begin
    mascara = '0;
    for (int c = 0; c < N_COLUNAS; c++) begin
      for (int l = 0; l < N_LINHAS; l++) begin
        mascara[c*N_LINHAS + l] = dentro &&
                                  (4'(c) >= col_ini_s) && (4'(c) <= col_fim_s) &&
                                  (4'(l) >= lin_ini_s) && (4'(l) <= lin_fim_s);
      end
    end
  end

endmodule

// File: rtl/gerenciador_de_posicionamento.sv
// Fleet placement controller: edge-detected confirm places ships one at a
// time after bounds and overlap checks, building the map used by the attack phase.
module gerenciador_de_posicionamento
  import batalha_naval_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic       orientacao,
  input  logic       confirmar,
  output logic [6:0] mapa0,
  output logic [6:0] mapa1,
  output logic [6:0] mapa2,
  output logic [6:0] mapa3,
  output logic [6:0] mapa4,
  output logic [6:0] previa0,
  output logic [6:0] previa1,
  output logic [6:0] previa2,
  output logic [6:0] previa3,
  output logic [6:0] previa4,
  output logic [1:0] navio_atual,
  output logic       pronto,
  output logic       LED_R,
  output logic       LED_G
);

  estado_t               estado_r;
  estado_t               estado_prox_s;
  logic                  confirmar_q_r;
  logic [N_CELULAS-1:0]  mapa_r;
  logic [N_CELULAS-1:0]  mapa_prox_s;
  logic [1:0]            navio_r;
  logic [1:0]            navio_prox_s;
  logic                  pronto_r;
  logic                  pronto_prox_s;
  logic                  led_r_r;
  logic                  led_r_prox_s;
  logic                  led_g_r;
  logic                  led_g_prox_s;
  logic [N_CELULAS-1:0]  mascara_s;
  logic [N_CELULAS-1:0]  previa_s;
  logic                  dentro_s;
  logic                  valido_s;
  logic                  aperto_s;

  mascara_navio u_mascara (
    .coluna     (coordColuna),
    .linha      (coordLinha),
    .orientacao (orientacao),
    .tamanho    (tamanho_do_navio(navio_r)),
    .mascara    (mascara_s),
    .dentro     (dentro_s)
  );

  // Press qualification and placement legality.
  always_comb begin
    aperto_s = confirmar & ~confirmar_q_r;
    valido_s = dentro_s && ((mascara_s & mapa_r) == '0);
    previa_s = mapa_r | mascara_s;
  end

  // Next-state and next-output logic; iniciar overrides any press.
  always_comb begin
    estado_prox_s = estado_r;
    mapa_prox_s   = mapa_r;
    navio_prox_s  = navio_r;
    pronto_prox_s = pronto_r;
    led_r_prox_s  = led_r_r;
    led_g_prox_s  = led_g_r;
    if (iniciar) begin
      estado_prox_s = POSICIONANDO;
      mapa_prox_s   = '0;
      navio_prox_s  = 2'd0;
      pronto_prox_s = 1'b0;
      led_r_prox_s  = 1'b0;
      led_g_prox_s  = 1'b0;
    end else begin
      case (estado_r)
        OCIOSO: begin
          estado_prox_s = OCIOSO;
        end
        POSICIONANDO: begin
          if (aperto_s && valido_s) begin
            mapa_prox_s  = mapa_r | mascara_s;
            led_g_prox_s = 1'b1;
            led_r_prox_s = 1'b0;
            if (navio_r == 2'(NUM_NAVIOS - 1)) begin
              estado_prox_s = CONCLUIDO;
              pronto_prox_s = 1'b1;
            end else begin
              navio_prox_s = navio_r + 2'd1;
            end
          end else if (aperto_s) begin
            led_r_prox_s = 1'b1;
            led_g_prox_s = 1'b0;
          end else begin
            estado_prox_s = POSICIONANDO;
          end
        end
        CONCLUIDO: begin
          estado_prox_s = CONCLUIDO;
        end
        default: begin
          estado_prox_s = OCIOSO;
        end
      endcase
    end
  end

  // State register; confirmar_q resets high so a held button is not a press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r      <= OCIOSO;
      confirmar_q_r <= 1'b1;
      mapa_r        <= '0;
      navio_r       <= 2'd0;
      pronto_r      <= 1'b0;
      led_r_r       <= 1'b0;
      led_g_r       <= 1'b0;
    end else begin
      estado_r      <= estado_prox_s;
      confirmar_q_r <= confirmar;
      mapa_r        <= mapa_prox_s;
      navio_r       <= navio_prox_s;
      pronto_r      <= pronto_prox_s;
      led_r_r       <= led_r_prox_s;
      led_g_r       <= led_g_prox_s;
    end
  end

  assign mapa0       = mapa_r[6:0];
  assign mapa1       = mapa_r[13:7];
  assign mapa2       = mapa_r[20:14];
  assign mapa3       = mapa_r[27:21];
  assign mapa4       = mapa_r[34:28];
  assign previa0     = previa_s[6:0];
  assign previa1     = previa_s[13:7];
  assign previa2     = previa_s[20:14];
  assign previa3     = previa_s[27:21];
  assign previa4     = previa_s[34:28];
  assign navio_atual = navio_r;
  assign pronto      = pronto_r;
  assign LED_R       = led_r_r;
  assign LED_G       = led_g_r;

endmodule

// File: tb/tb_gerenciador_de_posicionamento.sv
// Bench for gerenciador_de_posicionamento: cell-list reference model checked
// every falling edge, plus literal expectations from hand-worked placements.
module tb_gerenciador_de_posicionamento;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [2:0] coordColuna;
  logic [2:0] coordLinha;
  logic       orientacao;
  logic       confirmar;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic [6:0] previa0, previa1, previa2, previa3, previa4;
  logic [1:0] navio_atual;
  logic       pronto, LED_R, LED_G;

  int errors = 0;
  int checks = 0;

  gerenciador_de_posicionamento dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .coordColuna(coordColuna), .coordLinha(coordLinha),
    .orientacao(orientacao), .confirmar(confirmar),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
    .previa0(previa0), .previa1(previa1), .previa2(previa2),
    .previa3(previa3), .previa4(previa4),
    .navio_atual(navio_atual), .pronto(pronto), .LED_R(LED_R), .LED_G(LED_G)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int         sizes [3] = '{3, 2, 1};
  logic [34:0] m_map;
  int         m_navio;
  int         m_est;      // 0 idle, 1 placing, 2 done
  logic       m_led_r, m_led_g, m_pronto, m_conf_q;
  logic [34:0] m_mask;
  bit         m_ok;

  // Enumerate the cells of the candidate ship one by one.
  always_comb begin
    int cc, ll;
    m_mask = '0;
    m_ok   = (coordColuna <= 3'd4) && (coordLinha <= 3'd6);
    for (int k = 0; k < sizes[m_navio]; k++) begin
      cc = int'(coordColuna) + (orientacao ? 0 : k);
      ll = int'(coordLinha)  + (orientacao ? k : 0);
      if (cc > 4 || ll > 6) m_ok = 1'b0;
      else m_mask[cc*7 + ll] = 1'b1;
    end
    if (!m_ok) m_mask = '0;
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_map <= '0; m_navio <= 0; m_est <= 0;
      m_led_r <= 1'b0; m_led_g <= 1'b0; m_pronto <= 1'b0; m_conf_q <= 1'b1;
    end else begin
      m_conf_q <= confirmar;
      if (iniciar) begin
        m_map <= '0; m_navio <= 0; m_est <= 1;
        m_led_r <= 1'b0; m_led_g <= 1'b0; m_pronto <= 1'b0;
      end else if (m_est == 1 && confirmar && !m_conf_q) begin
        if (m_ok && ((m_mask & m_map) == '0)) begin
          m_map <= m_map | m_mask;
          m_led_g <= 1'b1; m_led_r <= 1'b0;
          if (m_navio == 2) begin
            m_est <= 2; m_pronto <= 1'b1;
          end else begin
            m_navio <= m_navio + 1;
          end
        end else begin
          m_led_r <= 1'b1; m_led_g <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nome, $time, atual, esperado);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    chk("mapa",   64'({mapa4, mapa3, mapa2, mapa1, mapa0}), 64'(m_map));
    chk("previa", 64'({previa4, previa3, previa2, previa1, previa0}), 64'(m_map | m_mask));
    chk("navio",  64'(navio_atual), 64'(m_navio));
    chk("pronto", 64'(pronto), 64'(m_pronto));
    chk("leds",   64'({LED_R, LED_G}), 64'({m_led_r, m_led_g}));
  end

  // ---------------- stimulus ----------------
  task automatic ciclo(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock); #1;
    end
  endtask

  task automatic apertar(input int c, input int l, input bit o);
    coordColuna = 3'(c); coordLinha = 3'(l); orientacao = o;
    confirmar = 1'b1;
    ciclo(1);
    confirmar = 1'b0;
    ciclo(1);
  endtask

  task automatic comecar();
    iniciar = 1'b1; ciclo(1); iniciar = 1'b0; ciclo(1);
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; confirmar = 1'b1;
    coordColuna = 3'd0; coordLinha = 3'd0; orientacao = 1'b0;
    ciclo(3);
    chk("reset_mapa0", 64'(mapa0), 64'd0);
    chk("reset_navio", 64'(navio_atual), 64'd0);
    reset = 1'b1; ciclo(2);
    confirmar = 1'b0; ciclo(1);
    apertar(0, 0, 1'b0);               // idle: ignored
    chk("ocioso_mapa0", 64'(mapa0), 64'd0);

    // Full fleet
    comecar();
    apertar(0, 0, 1'b0);
    chk("n0_mapa0", 64'(mapa0), 64'(7'b0000001));
    chk("n0_mapa2", 64'(mapa2), 64'(7'b0000001));
    chk("n0_ledg",  64'(LED_G), 64'd1);
    chk("n0_navio", 64'(navio_atual), 64'd1);
    apertar(4, 2, 1'b1);
    chk("n1_mapa4", 64'(mapa4), 64'(7'b0001100));
    chk("n1_navio", 64'(navio_atual), 64'd2);
    apertar(1, 5, 1'b0);
    chk("n2_mapa1", 64'(mapa1), 64'(7'b0100001));
    chk("n2_pronto", 64'(pronto), 64'd1);
    apertar(3, 3, 1'b0);               // done: ignored
    chk("fim_mapa3", 64'(mapa3), 64'd0);
    chk("fim_navio", 64'(navio_atual), 64'd2);

    // Out of bounds
    comecar();
    chk("ini_mapa1", 64'(mapa1), 64'd0);
    chk("ini_pronto", 64'(pronto), 64'd0);
    apertar(3, 0, 1'b0);
    chk("oob_h_ledr", 64'(LED_R), 64'd1);
    apertar(0, 6, 1'b1);
    chk("oob_v_ledr", 64'(LED_R), 64'd1);
    apertar(5, 0, 1'b0);
    chk("oob_c_ledr", 64'(LED_R), 64'd1);
    chk("oob_mapa0", 64'(mapa0), 64'd0);
    chk("oob_navio", 64'(navio_atual), 64'd0);

    // Overlap
    apertar(0, 0, 1'b0);
    apertar(1, 0, 1'b1);
    chk("ovl_ledr",  64'(LED_R), 64'd1);
    chk("ovl_mapa1", 64'(mapa1), 64'(7'b0000001));
    apertar(1, 1, 1'b1);
    chk("ovl_ok_mapa1", 64'(mapa1), 64'(7'b0000111));
    chk("ovl_ok_ledg",  64'(LED_G), 64'd1);

    // Held button: exactly one placement
    comecar();
    coordColuna = 3'd0; coordLinha = 3'd0; orientacao = 1'b0;
    confirmar = 1'b1; ciclo(10); confirmar = 1'b0; ciclo(1);
    chk("hold_navio", 64'(navio_atual), 64'd1);
    chk("hold_leds",  64'({LED_R, LED_G}), 64'(2'b01));

    // iniciar and press in the same cycle
    coordColuna = 3'd3; coordLinha = 3'd3; orientacao = 1'b1;
    iniciar = 1'b1; confirmar = 1'b1; ciclo(1);
    iniciar = 1'b0; ciclo(2); confirmar = 1'b0; ciclo(1);
    chk("inip_mapa3", 64'(mapa3), 64'd0);
    chk("inip_mapa0", 64'(mapa0), 64'd0);
    chk("inip_navio", 64'(navio_atual), 64'd0);

    // Reset mid-placement with the button held
    apertar(2, 0, 1'b1);
    coordColuna = 3'd0; coordLinha = 3'd0; orientacao = 1'b0;
    confirmar = 1'b1;
    #2 reset = 1'b0; #1;
    chk("rst_mapa2", 64'(mapa2), 64'd0);
    chk("rst_saidas", 64'({navio_atual, pronto, LED_R, LED_G}), 64'd0);
    ciclo(2);
    reset = 1'b1; ciclo(1);
    iniciar = 1'b1; ciclo(1); iniciar = 1'b0; ciclo(3);
    chk("rst_sem_aperto", 64'(mapa0), 64'd0);
    chk("rst_navio", 64'(navio_atual), 64'd0);
    confirmar = 1'b0; ciclo(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
